uart_rx_fifo: RTL and testbench

// - Parametrised UART receiver with on-chip receive FIFO; successor to the fixed 8-bit single-register receiver.
// - Sits between the shared baud_gen (oversample_tick) and the host-side valid/ready consumer.
// - Generalised in data width, stop-bit count and oversample ratio; adds buffering and overrun detection.

---
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with a show-ahead receive FIFO and sticky overrun flag.
// Optional line-break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          oversample_tick,
    input  logic                          rx,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_err,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          break_det
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned ENT_W  = DATA_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HOLD} state_t;
    state_t state_q, state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_d;
    logic [TICK_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_en_q, par_odd_q, par_err_q, frm_err_q;
    logic                   fall_c, half_c, samp_c, last_stop_c, push_c, frm_fin_c;
`ifdef UART_RX_BREAK_DET_EN
    logic                   brk_low_q, brk_c, is_brk_c, break_q;
`endif

    // Input synchroniser; presets high so reset does not look like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_d   <= rx_s;
        end
    end
    assign rx_s        = sync_q[SYNC_STAGES-1];
    assign fall_c      = rx_d & ~rx_s;
    assign half_c      = oversample_tick && (tick_cnt == TICK_W'(OVERSAMPLE/2 - 1));
    assign samp_c      = oversample_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign last_stop_c = (state_q == S_STOP) && samp_c && (stop_cnt == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin : next_state
        state_n = state_q;
        case (state_q)
            S_IDLE:   if (fall_c) state_n = S_START;
            S_START:  if (half_c) state_n = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (samp_c && (bit_cnt == BIT_W'(DATA_BITS - 1)))
                          state_n = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (samp_c) state_n = S_STOP;
            S_STOP:   if (last_stop_c) begin
`ifdef UART_RX_BREAK_DET_EN
                          state_n = brk_c ? S_HOLD : S_IDLE;
`else
                          state_n = S_IDLE;
`endif
                      end
            S_HOLD:   if (samp_c && rx_s) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        frm_fin_c = frm_err_q | ~rx_s;
`ifdef UART_RX_BREAK_DET_EN
        // Break: all-zero payload and the first stop bit low.
        is_brk_c = (shift_q == '0) && ((stop_cnt == 1'b0) ? ~rx_s : brk_low_q);
        push_c   = last_stop_c && !is_brk_c;
        brk_c    = last_stop_c && is_brk_c;
`else
        push_c   = last_stop_c;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_low_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (fall_c) begin
                        par_en_q  <= parity_en;
                        par_odd_q <= parity_odd;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                    end
                end
                S_START: if (oversample_tick) tick_cnt <= half_c ? '0 : tick_cnt + TICK_W'(1);
                S_DATA: if (oversample_tick) begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                    if (samp_c) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                S_PARITY: if (oversample_tick) begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                    if (samp_c) par_err_q <= ((^shift_q) ^ rx_s) != par_odd_q;
                end
                S_STOP: if (oversample_tick) begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                    if (samp_c) begin
                        stop_cnt <= stop_cnt + 1'b1;
                        if (!rx_s) frm_err_q <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        if (stop_cnt == 1'b0) brk_low_q <= ~rx_s;
`endif
                    end
                end
                // Re-arm only after a full bit period of continuous high line.
                S_HOLD: if (oversample_tick) tick_cnt <= rx_s ? tick_cnt + TICK_W'(1) : '0;
                default: tick_cnt <= '0;
            endcase
        end
    end

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [ENT_W-1:0] entry_c, head_q, head_n;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic             valid_q, full_c, pop_c, wr_c, ovr_c, ovr_q;

    assign entry_c = {shift_q, par_err_q, frm_fin_c};
    assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c   = valid_q && rx_ready;
    assign wr_c    = push_c && (!full_c || pop_c);
    assign ovr_c   = push_c && full_c && !pop_c;

    // Registered head entry tracks the post-update read pointer.
    always_comb begin : fifo_next
        rd_ptr_n = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_n  = count_q;
        if (wr_c && !pop_c)      count_n = count_q + CNT_W'(1);
        else if (!wr_c && pop_c) count_n = count_q - CNT_W'(1);
        if (count_n == '0)                     head_n = '0;
        else if (wr_c && (wr_ptr == rd_ptr_n)) head_n = entry_c;
        else                                   head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr] <= entry_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr  <= rd_ptr_n;
            count_q <= count_n;
            valid_q <= (count_n != '0);
            head_q  <= head_n;
            if (ovr_c)            ovr_q <= 1'b1;
            else if (overrun_clr) ovr_q <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) break_q <= 1'b0;
        else          break_q <= brk_c;
    end
    assign break_det = break_q;
`else
    assign break_det = 1'b0;
`endif

    assign rx_valid    = valid_q;
    assign rx_data     = head_q[ENT_W-1:2];
    assign parity_err  = head_q[1];
    assign frame_err   = head_q[0];
    assign overrun_err = ovr_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters; break expectations follow UART_RX_BREAK_DET_EN.
module tb_uart_rx_fifo;
    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLKS = 2 * OS;

    logic       clk = 1'b0;
    logic       reset_n, oversample_tick = 1'b0, rx, parity_en, parity_odd;
    logic       rx_valid, rx_ready, parity_err, frame_err, overrun_err, overrun_clr, break_det;
    logic [7:0] rx_data;
    logic [4:0] fifo_count;
    int         checks = 0, errors = 0, brk_pulses = 0;

    always #5 clk = ~clk;
    // One oversample tick every second clock.
    always @(posedge clk) oversample_tick <= ~oversample_tick;
    always @(negedge clk) if (break_det) brk_pulses++;

    uart_rx_fifo dut (
        .clk(clk), .reset_n(reset_n), .oversample_tick(oversample_tick), .rx(rx),
        .parity_en(parity_en), .parity_odd(parity_odd), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_data(rx_data), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .overrun_clr(overrun_clr), .fifo_count(fifo_count),
        .break_det(break_det)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic podd,
                              input logic flip, input logic stop_low);
        parity_en  = pe;
        parity_odd = podd;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit((^d) ^ podd ^ flip);
        send_bit(~stop_low);
        send_bit(1'b1);
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
        rx_ready = 1'b0; overrun_clr = 1'b0;
        wait_clks(3);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_data", 32'(rx_data), 32'h0);
        chk("rst_overrun", 32'(overrun_err), 32'h0);
        reset_n = 1'b1;
        wait_clks(4);

        // Even parity, correct parity bit.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("p55_valid", 32'(rx_valid), 32'h1);
        chk("p55_data", 32'(rx_data), 32'h55);
        chk("p55_perr", 32'(parity_err), 32'h0);
        chk("p55_ferr", 32'(frame_err), 32'h0);
        chk("p55_count", 32'(fifo_count), 32'h1);
        pop();
        chk("p55_pop_count", 32'(fifo_count), 32'h0);
        chk("p55_pop_valid", 32'(rx_valid), 32'h0);
        chk("p55_pop_data", 32'(rx_data), 32'h0);

        // Odd parity with the parity bit inverted.
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("a3_data", 32'(rx_data), 32'hA3);
        chk("a3_perr", 32'(parity_err), 32'h1);
        chk("a3_ferr", 32'(frame_err), 32'h0);
        pop();

        // Glitch shorter than half a bit is a false start.
        parity_en = 1'b0;
        rx = 1'b0;
        wait_clks(8);
        rx = 1'b1;
        wait_clks(3 * BIT_CLKS);
        chk("glitch_count", 32'(fifo_count), 32'h0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_glitch_data", 32'(rx_data), 32'h81);
        chk("after_glitch_count", 32'(fifo_count), 32'h1);
        pop();

        // Stop bit low.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("3c_data", 32'(rx_data), 32'h3C);
        chk("3c_ferr", 32'(frame_err), 32'h1);
        chk("3c_perr", 32'(parity_err), 32'h0);
        pop();

        // Seventeen frames into a sixteen-entry FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_count", 32'(fifo_count), 32'd16);
        chk("ovr_flag", 32'(overrun_err), 32'h1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_data_%0d", i), 32'(rx_data), 32'(i));
            pop();
        end
        chk("drain_count", 32'(fifo_count), 32'h0);
        chk("ovr_sticky", 32'(overrun_err), 32'h1);
        overrun_clr = 1'b1;
        wait_clks(1);
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun_err), 32'h0);

        // Line held low for two frame times.
        rx = 1'b0;
        wait_clks(20 * BIT_CLKS);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_count", 32'(fifo_count), 32'h0);
        chk("brk_pulses", 32'(brk_pulses), 32'h1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_brk_data", 32'(rx_data), 32'h5A);
`else
        chk("brk_count", 32'(fifo_count), 32'h1);
        chk("brk_data", 32'(rx_data), 32'h0);
        chk("brk_ferr", 32'(frame_err), 32'h1);
        chk("brk_pulses", 32'(brk_pulses), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
